clog2_engine: RTL and testbench

CLOG2_ENGINE -- requirements
Module: clog2_engine

---
 rtl/clog2_pkg.sv | 25 ++
 rtl/clog2_engine.sv | 76 +++++++
 tb/tb_clog2_engine.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/clog2_pkg.sv
// Shared definitions for the ceiling-log2 engine: FSM state encoding and a
// behavioural reference for clog2 that is usable from any consumer.
package clog2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // clog2(0)=0, clog2(1)=0, otherwise bit-length of (x-1).
  function automatic int unsigned clog2_ref(input int unsigned x);
    int unsigned y;
    int unsigned n;
    n = 0;
    if (x > 1) begin
      y = x - 1;
      for (int i = 0; i < 32; i++) begin
        if (y[i]) n = i + 1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/clog2_engine.sv
// Iterative ceiling-log2 engine. An accepted operand is reduced to (a-1),
// then shifted right one bit per cycle while a counter tracks the number of
// shifts; the count at x==0 is the bit-length of (a-1), i.e. clog2(a).
// Valid/ready handshakes on both sides; one operand in flight at a time.
module clog2_engine
  import clog2_pkg::*;
#(
  parameter int W  = 4,
  parameter int RW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_a,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_clog2,
  output logic          out_pow2
);

  state_t        r_state;
  logic [W-1:0]  r_x;
  logic [RW-1:0] r_cnt;
  logic          r_pow2;

  logic [W-1:0]  w_am1;
  logic          w_a_nz;
  logic          w_pow2;

  // a-1 is only formed for a nonzero operand so the subtraction never wraps.
  assign w_a_nz = (in_a != '0);
  assign w_am1  = w_a_nz ? (in_a - W'(1)) : '0;
  assign w_pow2 = w_a_nz && ((in_a & w_am1) == '0);

  // Control and shift/count datapath; x holds at most W bits, so cnt tops out at W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_cnt   <= '0;
      r_pow2  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x     <= w_am1;
            r_cnt   <= '0;
            r_pow2  <= w_pow2;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (r_x != '0) begin
            r_x   <= r_x >> 1;
            r_cnt <= r_cnt + RW'(1);
          end else begin
            r_state <= DONE;
          end
        end
        DONE: begin
          // Returning to IDLE here; a new operand is only taken next cycle.
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Results are gated so they read as zero whenever no result is offered.
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_clog2 = out_valid ? r_cnt : '0;
  assign out_pow2  = out_valid & r_pow2;

endmodule

// File: tb/tb_clog2_engine.sv
// Directed and sweep bench for clog2_engine at W=4 and W=8.
module tb_clog2_engine;
  import clog2_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       v4, r4, ir4, ov4, p4;
  logic [3:0] a4;
  logic [2:0] c4;
  logic       v8, r8, ir8, ov8, p8;
  logic [7:0] a8;
  logic [3:0] c8;

  int checks   = 0;
  int failures = 0;
  int cur      = 4;

  clog2_engine #(.W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(ir4), .in_a(a4),
    .out_valid(ov4), .out_ready(r4), .out_clog2(c4), .out_pow2(p4)
  );

  clog2_engine #(.W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(ir8), .in_a(a8),
    .out_valid(ov8), .out_ready(r8), .out_clog2(c8), .out_pow2(p8)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int g_ov(); return (cur == 8) ? int'(ov8) : int'(ov4); endfunction
  function automatic int g_ir(); return (cur == 8) ? int'(ir8) : int'(ir4); endfunction
  function automatic int g_c();  return (cur == 8) ? int'(c8)  : int'(c4);  endfunction
  function automatic int g_p();  return (cur == 8) ? int'(p8)  : int'(p4);  endfunction

  task automatic set_in(input int v, input int a);
    if (cur == 8) begin v8 = v[0]; a8 = a[7:0]; end
    else          begin v4 = v[0]; a4 = a[3:0]; end
  endtask

  task automatic set_rdy(input int r);
    if (cur == 8) r8 = r[0];
    else          r4 = r[0];
  endtask

  // mode 0: plain; 1: toggle in_a every cycle after accept;
  // 2: keep in_valid high with a junk operand until the result appears.
  task automatic run_op(input int a, input int gap, input int mode,
                        output int c, output int p, output int lat);
    int t;
    int tg;
    c = 0; p = 0; lat = 0; t = 0;
    while (g_ir() == 0 && t < 50) begin tick(); t++; end
    if (g_ir() == 0) begin chk("ready_timeout", 0, 1); return; end
    set_in(1, a);
    tick();
    lat = 1;
    tg = a;
    if (mode == 2) set_in(1, (1 << cur) - 1);
    else if (mode == 1) begin tg = ~tg; set_in(0, tg); end
    else set_in(0, a);
    while (g_ov() == 0 && lat < 60) begin
      if (mode == 1) begin tg = ~tg; set_in(0, tg); end
      tick();
      lat++;
    end
    set_in(0, 0);
    if (g_ov() == 0) begin chk("done_timeout", 0, 1); return; end
    c = g_c();
    p = g_p();
    for (int i = 0; i < gap; i++) begin
      tick();
      chk("hold_valid", g_ov(), 1);
      chk("hold_clog2", g_c(), c);
      chk("hold_pow2", g_p(), p);
      chk("hold_in_ready", g_ir(), 0);
    end
    set_rdy(1);
    tick();
    set_rdy(0);
    chk("post_valid", g_ov(), 0);
    chk("post_in_ready", g_ir(), 1);
    chk("post_clog2_zero", g_c(), 0);
    chk("post_pow2_zero", g_p(), 0);
  endtask

  task automatic directed(input string tag, input int a, input int gap, input int mode,
                          input int ec, input int ep, input int el);
    int c, p, lat;
    run_op(a, gap, mode, c, p, lat);
    chk({tag, "_clog2"}, c, ec);
    chk({tag, "_pow2"}, p, ep);
    chk({tag, "_latency"}, lat, el);
  endtask

  initial begin
    int c, p, lat, ec, ep;
    rst_n = 1'b0;
    v4 = 0; r4 = 0; a4 = '0;
    v8 = 0; r8 = 0; a8 = '0;
    repeat (3) tick();
    chk("rst_in_ready4", ir4, 1);
    chk("rst_out_valid4", ov4, 0);
    chk("rst_clog2_4", c4, 0);
    chk("rst_pow2_4", p4, 0);
    chk("rst_in_ready8", ir8, 1);
    chk("rst_out_valid8", ov8, 0);
    rst_n = 1'b1;

    cur = 4;
    directed("a0",  0,  0, 0, 0, 0, 2);
    directed("a1",  1,  1, 0, 0, 1, 2);
    directed("a2",  2,  0, 0, 1, 1, 3);
    directed("a5",  5,  2, 0, 3, 0, 5);
    directed("a15", 15, 0, 0, 4, 0, 6);
    directed("hold8", 8, 5, 0, 3, 1, 5);
    directed("toggle9", 9, 0, 1, 4, 0, 6);
    directed("busyvalid5", 5, 1, 2, 3, 0, 5);
    repeat (4) begin
      tick();
      chk("no_queued_result", ov4, 0);
    end

    // Abort an operation mid-flight, then accept on the first cycle after release.
    set_in(1, 15);
    tick();
    set_in(0, 15);
    tick();
    chk("abort_busy", ir4, 0);
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("abort_valid", ov4, 0);
      chk("abort_in_ready", ir4, 1);
    end
    rst_n = 1'b1;
    directed("after_rst3", 3, 0, 0, 2, 0, 4);

    cur = 4;
    for (int a = 0; a < 16; a++) begin
      run_op(a, $urandom_range(0, 3), 0, c, p, lat);
      ec = int'(clog2_ref(a));
      ep = (a != 0 && (a & (a - 1)) == 0) ? 1 : 0;
      chk("sweep4_clog2", c, ec);
      chk("sweep4_pow2", p, ep);
      chk("sweep4_latency", lat, 2 + ec);
    end

    cur = 8;
    for (int a = 0; a < 256; a++) begin
      run_op(a, $urandom_range(0, 3), 0, c, p, lat);
      ec = int'(clog2_ref(a));
      ep = (a != 0 && (a & (a - 1)) == 0) ? 1 : 0;
      chk("sweep8_clog2", c, ec);
      chk("sweep8_pow2", p, ep);
      chk("sweep8_latency", lat, 2 + ec);
    end
    directed("w8_255", 255, 0, 0, 8, 0, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
